deser8way: RTL and testbench
============================

DESER8WAY -- requirements
Module: deser8way

Interface
REQ-001 Parameter: LSB_FIRST, default 1, bit order. 1 means the first accepted bit lands in out[0]; 0 means it lands in out[7].
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_bit  input  1  serial data bit.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_ready  output  1  block can accept a bit this cycle.
REQ-007 flush  input  1  discard the partial word.
REQ-008 out  output  8  assembled parallel word.
REQ-009 out_valid  output  1  out holds a complete word.
REQ-010 out_ready  input  1  consumer takes the word this cycle.
REQ-011 any  output  1  registered OR of all 8 bits of out.
REQ-012 busy  output  1  a partial word is in progress (state SHIFT).

Function
REQ-013 The block SHALL implement three states:
- IDLE: count 0, no bits held.
- SHIFT: 1 to 7 bits held.
- FULL: word complete, waiting for the consumer.
REQ-014 in_ready SHALL be 1 in IDLE and SHIFT and 0 in FULL, decoded from registered state only, with no combinational path from any input.
REQ-015 A bit SHALL be accepted only on a cycle where in_valid=1, in_ready=1 and flush=0.
REQ-016 Each accepted bit SHALL be written into the internal shift register at position count (LSB_FIRST=1) or 7-count (LSB_FIRST=0), and the 3-bit count SHALL increment.
REQ-017 State transitions on an accepted bit:
- IDLE goes to SHIFT.
- SHIFT stays in SHIFT while count is below 7.
- On the 8th accept (count=7), count SHALL wrap to 0 and the state SHALL go to FULL.
REQ-018 On the 8th-accept edge, out SHALL be loaded with the complete word, out_valid SHALL be set to 1, and any SHALL be set to the OR of that word; out_valid and any are therefore valid the cycle after the 8th accept.
REQ-019 out and any SHALL change only on the 8th-accept edge or on reset; they hold their value between words, including after the word is drained.
REQ-020 In FULL, when out_valid=1 and out_ready=1, the block SHALL go to IDLE and clear out_valid on that edge, so in_ready=1 the following cycle.
REQ-021 In FULL with out_ready=0, the block SHALL hold out, out_valid and any stable indefinitely.
REQ-022 flush=1 in IDLE or SHIFT SHALL clear count and the shift register and move to IDLE. If in_valid=1 on the same cycle, that bit SHALL be discarded.
REQ-023 flush=1 in FULL SHALL have no effect; the complete word is never discarded.
REQ-024 in_valid=0 in SHIFT SHALL hold count and the partial word, with no timeout.
REQ-025 Minimum time per word SHALL be 9 cycles: 8 accepts plus 1 FULL cycle with out_ready=1.
REQ-026 busy SHALL be 1 exactly when the state is SHIFT.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL force: state IDLE, count 0, shift register 0, out=8'h00, out_valid=0, any=0, busy=0.
REQ-028 rst SHALL override every other input, including during SHIFT (partial word lost) and in FULL (word lost, out cleared).
REQ-029 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-030 LSB_FIRST=1, 8 back-to-back bits 1,0,1,1,0,0,0,1 -> out=8'h8D, out_valid=1 and any=1 one cycle after the 8th accept; in_ready=0 while out_ready=0.
REQ-031 LSB_FIRST=0, same bit sequence -> out=8'hB1, any=1.
REQ-032 8 zero bits -> out=8'h00, out_valid=1, any=0; out_ready asserted 5 cycles later -> out_valid=0 and in_ready=1 on the next cycle, out still 8'h00.
REQ-033 3 bits accepted, then flush=1 together with in_valid=1 -> busy=0, count 0, that bit dropped; next 8 bits of all 1 -> out=8'hFF.
REQ-034 rst pulsed after 5 accepted bits, and separately while in FULL with out=8'hFF -> all outputs at reset values the next cycle; a fresh 8 bits forms a clean word.
REQ-035 Random in_valid/out_ready gaps, 1000 words checked against a reference model -> no lost, duplicated or reordered bits; out stable while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/deser8way_if.sv
// Handshake/bus bundle for the 8-way serial-to-parallel deserializer.
// master drives serial input and consumer ready; slave is the deserializer.
interface deser8way_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       any;
  logic       busy;

  modport master (
    output in_bit, in_valid, flush, out_ready,
    input  in_ready, out, out_valid, any, busy
  );

  modport slave (
    input  in_bit, in_valid, flush, out_ready,
    output in_ready, out, out_valid, any, busy
  );
endinterface

// File: rtl/deser8way.sv
// Collects 8 serial bits into a byte and holds it until the consumer takes it.
// Bit placement is selected by LSB_FIRST; flush drops a partial word only.
module deser8way #(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rst,
  deser8way_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] pos;
  logic [7:0] sreg;
  logic [7:0] sreg_nxt;
  logic [7:0] out_q;
  logic       ov_q;
  logic       any_q;

  assign pos = LSB_FIRST ? cnt : 3'(3'd7 - cnt);

  // Word as it will look once the current bit lands; on the 8th bit this is the output word.
  always_comb begin
    sreg_nxt      = sreg;
    sreg_nxt[pos] = bus.in_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      sreg  <= 8'h00;
      out_q <= 8'h00;
      ov_q  <= 1'b0;
      any_q <= 1'b0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (bus.flush) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sreg  <= 8'h00;
          end else if (bus.in_valid) begin
            if (cnt == 3'd7) begin
              state <= FULL;
              cnt   <= 3'd0;
              sreg  <= 8'h00;
              out_q <= sreg_nxt;
              any_q <= |sreg_nxt;
              ov_q  <= 1'b1;
            end else begin
              state <= SHIFT;
              cnt   <= cnt + 3'd1;
              sreg  <= sreg_nxt;
            end
          end
        end
        // flush is deliberately ignored here: a complete word is never dropped.
        FULL: begin
          if (bus.out_ready) begin
            state <= IDLE;
            ov_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state != FULL);
  assign bus.busy      = (state == SHIFT);
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.any       = any_q;
endmodule

// File: tb/tb_deser8way.sv
// Bench for deser8way: both bit orders side by side against a bit-queue model,
// directed vectors with literal expectations, then 1000 random-gap words.
module tb_deser8way;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_bit = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;

  always #5 clk = ~clk;

  deser8way_if b1();
  deser8way_if b0();

  assign b1.in_bit = in_bit;   assign b0.in_bit = in_bit;
  assign b1.in_valid = in_valid; assign b0.in_valid = in_valid;
  assign b1.flush = flush;     assign b0.flush = flush;
  assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;

  deser8way #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(b1));
  deser8way #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(b0));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Model: accepted bits in a queue; a word is formed arithmetically once 8 are in.
  bit         bits_q[$];
  bit         m_full = 1'b0;
  bit         m_init = 1'b0;
  logic [7:0] m_out_l = 8'h00;
  logic [7:0] m_out_m = 8'h00;
  bit         m_any = 1'b0;
  bit         sb_en = 1'b0;
  logic [7:0] sent_q[$];
  int         drained = 0;

  // Compare current state at the falling edge, then advance the model with the
  // inputs the DUT will see on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("out_lsb",   b1.out, m_out_l);
      chk("out_msb",   b0.out, m_out_m);
      chk("valid_lsb", 8'(b1.out_valid), 8'(m_full));
      chk("valid_msb", 8'(b0.out_valid), 8'(m_full));
      chk("any_lsb",   8'(b1.any), 8'(m_any));
      chk("any_msb",   8'(b0.any), 8'(m_any));
      chk("ready_lsb", 8'(b1.in_ready), 8'(!m_full));
      chk("ready_msb", 8'(b0.in_ready), 8'(!m_full));
      chk("busy_lsb",  8'(b1.busy), 8'(bits_q.size() != 0 && !m_full));
      chk("busy_msb",  8'(b0.busy), 8'(bits_q.size() != 0 && !m_full));
      if (sb_en && b1.out_valid && out_ready && !rst) begin
        if (sent_q.size() == 0) begin
          chk("sb_extra_word", 8'h01, 8'h00);
        end else begin
          chk("sb_word_lsb", b1.out, sent_q[0]);
          chk("sb_word_msb", b0.out, rev8(sent_q[0]));
          void'(sent_q.pop_front());
        end
        drained++;
      end
    end
    if (rst) begin
      bits_q.delete();
      m_full = 1'b0; m_out_l = 8'h00; m_out_m = 8'h00; m_any = 1'b0; m_init = 1'b1;
    end else if (m_full) begin
      if (out_ready) m_full = 1'b0;
    end else if (flush) begin
      bits_q.delete();
    end else if (in_valid) begin
      bits_q.push_back(in_bit);
      if (bits_q.size() == 8) begin
        m_out_l = 8'h00; m_out_m = 8'h00;
        for (int i = 0; i < 8; i++) begin
          m_out_l = m_out_l + (8'(bits_q[i]) << i);
          m_out_m = m_out_m + (8'(bits_q[i]) << (7 - i));
        end
        m_any  = (m_out_l != 8'h00);
        m_full = 1'b1;
        bits_q.delete();
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!b1.in_ready) begin
      step(1);
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 8'(b1.in_ready), 8'h01);
        return;
      end
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    in_valid = 1'b0;
    step(gap);
    wait_ready();
    in_valid = 1'b1;
    in_bit   = b;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    chk("rst_out", b1.out, 8'h00);
    chk("rst_busy", 8'(b1.busy), 8'h00);
    rst = 1'b0;
    step(1);
    chk("ready_after_rst", 8'(b1.in_ready), 8'h01);

    // 1,0,1,1,0,0,0,1 back-to-back, consumer stalled
    send_byte(8'h8D);
    chk("word_8d_lsb", b1.out, 8'h8D);
    chk("word_b1_msb", b0.out, 8'hB1);
    chk("word_8d_valid", 8'(b1.out_valid), 8'h01);
    chk("word_8d_any", 8'(b1.any), 8'h01);
    chk("full_not_ready", 8'(b1.in_ready), 8'h00);
    step(3);
    chk("full_hold", b1.out, 8'h8D);
    drain();
    chk("held_after_drain", b1.out, 8'h8D);

    // all-zero word, drained 5 cycles later
    send_byte(8'h00);
    chk("zero_valid", 8'(b1.out_valid), 8'h01);
    chk("zero_any", 8'(b1.any), 8'h00);
    step(4);
    drain();
    chk("zero_drained_valid", 8'(b1.out_valid), 8'h00);
    chk("zero_drained_ready", 8'(b1.in_ready), 8'h01);
    chk("zero_drained_out", b1.out, 8'h00);

    // 3 bits, then flush with a colliding valid 0 bit
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    chk("partial_busy", 8'(b1.busy), 8'h01);
    in_valid = 1'b1; in_bit = 1'b0; flush = 1'b1;
    step(1);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_busy", 8'(b1.busy), 8'h00);
    send_byte(8'hFF);
    chk("ones_word", b1.out, 8'hFF);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_in_full_valid", 8'(b1.out_valid), 8'h01);
    chk("flush_in_full_out", b1.out, 8'hFF);

    // reset while FULL
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_full_out", b1.out, 8'h00);
    chk("rst_full_valid", 8'(b1.out_valid), 8'h00);
    chk("rst_full_any", 8'(b1.any), 8'h00);
    chk("rst_full_ready", 8'(b1.in_ready), 8'h01);

    // reset after 5 accepted bits, then a clean word
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_shift_busy", 8'(b1.busy), 8'h00);
    send_byte(8'h96);
    chk("clean_lsb", b1.out, 8'h96);
    chk("clean_msb", b0.out, 8'h69);
    drain();

    // random gaps on both sides, scoreboard on every drained word
    sb_en = 1'b1;
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          logic [7:0] v;
          v = 8'($urandom);
          sent_q.push_back(v);
          for (int i = 0; i < 8; i++)
            send_bit(v[i], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
      end
      begin
        int guard = 0;
        while (drained < 1000 && guard < 60000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          step(1);
          guard++;
        end
        out_ready = 1'b0;
      end
    join
    step(2);
    chk("sb_drained", 8'(drained == 1000), 8'h01);
    chk("sb_left", 8'(sent_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
